pkt_switch_n: RTL and testbench
===============================

# pkt_switch_n

Parametrised store-through packet switch: one ingress byte stream is routed to one of `NUM_PORTS` egress ports by matching the packet's destination byte against per-port programmable addresses. Each egress port has its own FIFO, so a slow reader never corrupts data. Ingress back-pressure protects against overflow, and unmatched packets are dropped cleanly. It sits between the ingress framer and the per-port consumers and is configured over the same simple memory-style interface as the existing 4-port switch.

## Interface
- `NUM_PORTS`, 4: egress port count, ≥2.
- `DW`, 8: data/address/length width.
- `FIFO_DEPTH`, 16: entries per egress FIFO, power of two, ≥4.
- `CAW`, `$clog2(2*NUM_PORTS+1)`: config address width (derived).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_en` in 1: config access strobe.
- `cfg_wr` in 1: 1 = write, 0 = read.
- `cfg_addr` in CAW: register index.
- `cfg_wdata` in DW: write data.
- `cfg_rdata` out DW: read data, registered.
- `in_data` in DW: ingress byte.
- `in_valid` in 1: ingress byte present.
- `in_ready` out 1: switch accepts the byte this cycle.
- `out_data` out NUM_PORTS×DW: packed head-of-FIFO data, port i at `[i*DW +: DW]`.
- `out_valid` out NUM_PORTS: FIFO i is non-empty.
- `out_read` in NUM_PORTS: pop FIFO i.

## Operation
- Packet format: byte0 = destination, byte1 = source, byte2 = payload length L, then L payload bytes. Total is L+3 bytes; L=0 is legal.
- A byte transfers when `in_valid && in_ready` at a rising edge.
- FSM states:
  - IDLE: awaiting byte0. On transfer, compare byte0 with `port_addr[0..N-1]`.
    - On a match, latch `sel` = lowest matching index, write byte0 to FIFO[sel], go to HDR.
    - On no match, go to DROP.
  - HDR: bytes 1 and 2 are written to FIFO[sel]. Byte2 loads `remain = L`.
    - If L=0, go to IDLE after byte2.
    - Otherwise go to PAY.
  - PAY: each byte is written to FIFO[sel] and decrements `remain`. Go to IDLE when the byte with `remain==1` transfers.
  - DROP: consume and discard the packet, tracking length identically to HDR/PAY. Return to IDLE after the last byte. `in_ready` is 1 throughout DROP.
- `in_ready`:
  - IDLE and DROP: 1.
  - HDR and PAY: `!full[sel]`.
  - `in_ready` never depends on `out_read` in the same cycle.
- Egress FIFOs are first-word-fall-through:
  - `out_valid[i] = !empty[i]` and `out_data[i]` = head.
  - `out_read[i]` while empty is ignored.
  - Push and pop in the same cycle on a non-full, non-empty FIFO keeps the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits.
- Config writes:
  - Index i < N sets `port_addr[i]`.
  - Accepted in any cycle and processed concurrently with ingress.
  - A write in the same cycle as a byte0 transfer takes effect on the next packet; the match uses the pre-write value.
- Config reads: `cfg_rdata` is updated on the edge after `cfg_en && !cfg_wr`, and holds otherwise.
  - Index < N returns `port_addr`.
  - Unmapped indices return 0.
- Writes to read-only or unmapped indices are ignored.

## Timing
- Reset values:
  - `port_addr[i] = i`
  - FSM = IDLE
  - all FIFOs empty
  - `out_valid = 0`, `out_data = 0`
  - `cfg_rdata = 0`
  - `in_ready = 1`
  - counters 0
- Ingress-to-egress latency is 1 cycle: a byte accepted at edge k gives `out_valid` high after edge k.
- Reset mid-packet: the FSM and all FIFOs are flushed, the partial packet is lost, and the next byte is treated as byte0.
- Sustained throughput is 1 byte per cycle when the selected FIFO is not full.

## Configuration
- `PKT_SWITCH_STATS_EN` defined: adds read-only statistics counters, each DW bits wide and wrapping.
  - Index N+i: packets fully forwarded to port i. Increments when the last byte is written.
  - Index 2N: packets dropped. Increments when the last DROP byte is consumed.
- `PKT_SWITCH_STATS_EN` undefined:
  - No counters are built.
  - Indices ≥ N read 0.
  - Everything else is unchanged.

## Structure
- Package `pkt_switch_pkg`:
  - FSM enum `sw_state_e` {IDLE, HDR, PAY, DROP}.
  - Header offset constants `HDR_DST=0`, `HDR_SRC=1`, `HDR_LEN=2`.
- Sub-module `pkt_sync_fifo` (DW, DEPTH): FWFT, with `full`, `empty` and `count`. Instantiate it NUM_PORTS times in a generate loop.

## Test plan
- Reset, then read indices 0–3 → `cfg_rdata` = 0,1,2,3.
  - `in_ready=1` and `out_valid=0`.
- Write `port_addr[2]=0x55`. Send packet 55,01,03,AA,BB,CC → port2 outputs exactly 6 bytes in order.
  - Other ports stay empty.
  - With STATS_EN, index N+2 reads 1.
- Send a packet with dest 0x77 (no match) and L=2 → no FIFO writes and `in_ready` stays 1.
  - The next packet routes correctly.
  - With STATS_EN, index 2N reads 1.
- Hold `out_read[1]=0` and send a 20-byte packet to port1 (DEPTH 16) → `in_ready` drops after 16 bytes.
  - Popping resumes flow.
  - All 20 bytes arrive in order.
- Both `port_addr[0]` and `port_addr[3]` = 0x10, with an L=0 packet to 0x10 → 3 bytes go to port0 only.
  - The FSM returns to IDLE immediately after byte2.
- Assert `rst` after byte 4 of a packet to port1 → all `out_valid=0` next cycle.
  - A fresh packet afterwards routes correctly.

Source files
------------

// File: rtl/pkt_switch_pkg.sv
// ============================================================================
// Module      : pkt_switch_pkg
// Description : Shared types and constants for the packet switch. Holds the
//               ingress FSM encoding and the packet header byte offsets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkt_switch_pkg;

    // Ingress FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        DROP = 2'd3
    } sw_state_e;

    // Header byte offsets within a packet
    localparam logic [1:0] HDR_DST = 2'd0;
    localparam logic [1:0] HDR_SRC = 2'd1;
    localparam logic [1:0] HDR_LEN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pkt_sync_fifo.sv
// ============================================================================
// Module      : pkt_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Head data is
//               presented on dout while not empty (0 when empty). Pushes
//               while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop_ok};
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    // Storage array; left unreset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pkt_switch_n.sv
// ============================================================================
// Module      : pkt_switch_n
// Description : Store-through packet switch. Routes each ingress packet to
//               the lowest-indexed egress port whose programmed address
//               matches the destination byte; unmatched packets are dropped.
//               Optional macro PKT_SWITCH_STATS_EN adds read-only per-port
//               forward counters and a drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_switch_n
    import pkt_switch_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CAW        = $clog2(2*NUM_PORTS+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_en,
    input  logic                    cfg_wr,
    input  logic [CAW-1:0]          cfg_addr,
    input  logic [DW-1:0]           cfg_wdata,
    output logic [DW-1:0]           cfg_rdata,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_PORTS*DW-1:0] out_data,
    output logic [NUM_PORTS-1:0]    out_valid,
    input  logic [NUM_PORTS-1:0]    out_read
);

    localparam int SW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HDR  = HDR;
    localparam logic [1:0] ST_PAY  = PAY;
    localparam logic [1:0] ST_DROP = DROP;

    logic [1:0]    state_q,    state_d;
    logic [SW-1:0] sel_q,      sel_d;
    logic [1:0]    hdr_pos_q,  hdr_pos_d;
    logic [DW-1:0] remain_q,   remain_d;
    logic          drop_pay_q, drop_pay_d;
    logic [DW-1:0] port_addr_q [NUM_PORTS];
    logic [DW-1:0] port_addr_d [NUM_PORTS];
    logic [DW-1:0] cfg_rdata_q, cfg_rdata_d;

    logic                         xfer;
    logic                         match;
    logic [SW-1:0]                match_idx;
    logic [NUM_PORTS-1:0]         fifo_push;
    logic [NUM_PORTS-1:0]         fifo_full;
    logic [NUM_PORTS-1:0]         fifo_empty;
    logic [NUM_PORTS*(AW+1)-1:0]  fifo_count;
    logic                         fwd_done;
    logic                         drop_done;

    assign in_ready  = ((state_q == ST_HDR) || (state_q == ST_PAY)) ? !fifo_full[sel_q] : 1'b1;
    assign xfer      = in_valid && in_ready;
    assign out_valid = ~fifo_empty;
    assign cfg_rdata = cfg_rdata_q;

    // Destination lookup: scan downward so the lowest matching port wins
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (in_data == port_addr_q[i]) begin
                match     = 1'b1;
                match_idx = SW'(i);
            end
        end
    end

    // Ingress FSM: header tracking, payload countdown, FIFO push steering
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        hdr_pos_d  = hdr_pos_q;
        remain_d   = remain_q;
        drop_pay_d = drop_pay_q;
        fifo_push  = '0;
        fwd_done   = 1'b0;
        drop_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    hdr_pos_d  = HDR_SRC;
                    drop_pay_d = 1'b0;
                    if (match) begin
                        sel_d                = match_idx;
                        fifo_push[match_idx] = 1'b1;
                        state_d              = ST_HDR;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    fifo_push[sel_q] = 1'b1;
                    if (hdr_pos_q == HDR_LEN) begin
                        remain_d = in_data;
                        if (in_data == '0) begin
                            state_d  = ST_IDLE;
                            fwd_done = 1'b1;
                        end else begin
                            state_d = ST_PAY;
                        end
                    end else begin
                        hdr_pos_d = HDR_LEN;
                    end
                end
            end
            ST_PAY: begin
                if (xfer) begin
                    fifo_push[sel_q] = 1'b1;
                    remain_d         = remain_q - 1'b1;
                    if (remain_q == DW'(1)) begin
                        state_d  = ST_IDLE;
                        fwd_done = 1'b1;
                    end
                end
            end
            default: begin
                // Drop path mirrors HDR/PAY length tracking without writes
                if (xfer) begin
                    if (!drop_pay_q) begin
                        if (hdr_pos_q == HDR_LEN) begin
                            remain_d = in_data;
                            if (in_data == '0) begin
                                state_d   = ST_IDLE;
                                drop_done = 1'b1;
                            end else begin
                                drop_pay_d = 1'b1;
                            end
                        end else begin
                            hdr_pos_d = HDR_LEN;
                        end
                    end else begin
                        remain_d = remain_q - 1'b1;
                        if (remain_q == DW'(1)) begin
                            state_d   = ST_IDLE;
                            drop_done = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

`ifdef PKT_SWITCH_STATS_EN
    logic [DW-1:0] fwd_cnt_q [NUM_PORTS];
    logic [DW-1:0] fwd_cnt_d [NUM_PORTS];
    logic [DW-1:0] drop_cnt_q, drop_cnt_d;

    // Statistics: count completed forwards per port and completed drops
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q + {{(DW-1){1'b0}}, drop_done};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (fwd_done && (sel_q == SW'(i))) begin
                fwd_cnt_d[i] = fwd_cnt_q[i] + 1'b1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                fwd_cnt_q[i] <= '0;
            end
        end else begin
            drop_cnt_q <= drop_cnt_d;
            fwd_cnt_q  <= fwd_cnt_d;
        end
    end
`else
    logic stats_unused;
    assign stats_unused = fwd_done ^ drop_done;
`endif

    logic count_unused;
    assign count_unused = ^fifo_count;

    // Config write decode and registered read mux
    always_comb begin
        port_addr_d = port_addr_q;
        cfg_rdata_d = cfg_rdata_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cfg_en && cfg_wr && (cfg_addr == CAW'(i))) begin
                port_addr_d[i] = cfg_wdata;
            end
        end
        if (cfg_en && !cfg_wr) begin
            cfg_rdata_d = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cfg_addr == CAW'(i)) begin
                    cfg_rdata_d = port_addr_q[i];
                end
`ifdef PKT_SWITCH_STATS_EN
                if (cfg_addr == CAW'(NUM_PORTS + i)) begin
                    cfg_rdata_d = fwd_cnt_q[i];
                end
`endif
            end
`ifdef PKT_SWITCH_STATS_EN
            if (cfg_addr == CAW'(2 * NUM_PORTS)) begin
                cfg_rdata_d = drop_cnt_q;
            end
`endif
        end
    end

    // Control and configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            hdr_pos_q   <= HDR_DST;
            remain_q    <= '0;
            drop_pay_q  <= 1'b0;
            cfg_rdata_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_addr_q[i] <= DW'(i);
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            hdr_pos_q   <= hdr_pos_d;
            remain_q    <= remain_d;
            drop_pay_q  <= drop_pay_d;
            cfg_rdata_q <= cfg_rdata_d;
            port_addr_q <= port_addr_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_fifo
            pkt_sync_fifo #(
                .DW    (DW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (fifo_push[g]),
                .din   (in_data),
                .pop   (out_read[g]),
                .dout  (out_data[g*DW +: DW]),
                .full  (fifo_full[g]),
                .empty (fifo_empty[g]),
                .count (fifo_count[g*(AW+1) +: (AW+1)])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pkt_switch_n.sv
// ============================================================================
// Module      : tb_pkt_switch_n
// Description : Self-checking bench for pkt_switch_n. Expected egress bytes
//               are queued per port as ingress bytes are accepted and popped
//               as the egress FIFOs are drained.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_switch_n;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CAW = $clog2(2*N+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_en = 1'b0;
    logic            cfg_wr = 1'b0;
    logic [CAW-1:0]  cfg_addr = '0;
    logic [DW-1:0]   cfg_wdata = '0;
    logic [DW-1:0]   cfg_rdata;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_read = '0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q [N][$];

    pkt_switch_n #(
        .NUM_PORTS  (N),
        .DW         (DW),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_read  (out_read)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [7:0] val);
        cfg_en    = 1'b1;
        cfg_wr    = 1'b1;
        cfg_addr  = CAW'(idx);
        cfg_wdata = val;
        tick();
        cfg_en = 1'b0;
        cfg_wr = 1'b0;
    endtask

    task automatic cfg_check(input int idx, input logic [7:0] exp, input string name);
        cfg_en   = 1'b1;
        cfg_wr   = 1'b0;
        cfg_addr = CAW'(idx);
        tick();
        cfg_en = 1'b0;
        vectors++;
        if (cfg_rdata !== exp) begin
            miscompares++;
            $display("FAIL %s: cfg_rdata[%0d] got %h expected %h", name, idx, cfg_rdata, exp);
        end
    endtask

    // Present one byte, wait for acceptance, record its expected egress port
    task automatic send_byte(input logic [7:0] b, input int port);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for byte %h", b);
        end
        if (port >= 0) exp_q[port].push_back(b);
        tick();
        in_valid = 1'b0;
    endtask

    // Pop count bytes from port p, comparing each against the scoreboard
    task automatic drain_port(input int p, input int count);
        int got;
        int cyc;
        logic [7:0] e;
        got = 0;
        cyc = 0;
        while (got < count && cyc < 500) begin
            if (out_valid[p]) begin
                vectors++;
                if (exp_q[p].size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_extra: port %0d got %h expected nothing", p, out_data[p*8 +: 8]);
                end else begin
                    e = exp_q[p].pop_front();
                    if (out_data[p*8 +: 8] !== e) begin
                        miscompares++;
                        $display("FAIL drain_data: port %0d got %h expected %h", p, out_data[p*8 +: 8], e);
                    end
                end
                got++;
                out_read[p] = 1'b1;
            end else begin
                out_read[p] = 1'b0;
            end
            tick();
            cyc++;
        end
        out_read[p] = 1'b0;
        if (got < count) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: port %0d got %0d bytes expected %0d", p, got, count);
        end
    endtask

    task automatic check_valid(input logic [N-1:0] exp, input string name);
        vectors++;
        if (out_valid !== exp) begin
            miscompares++;
            $display("FAIL %s: out_valid got %b expected %b", name, out_valid, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== '0 || out_data !== '0 || cfg_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h rdata=%h expected 1,0,0,0",
                     in_ready, out_valid, out_data, cfg_rdata);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < N; i++) cfg_check(i, 8'(i), "reset_addr");
        cfg_check(2*N, 8'h00, "reset_high_index");
        check_valid('0, "reset_valid");
    endtask

    task automatic test_route();
        cfg_write(2, 8'h55);
        cfg_check(2, 8'h55, "addr_writeback");
        send_byte(8'h55, 2);
        check_valid(4'b0100, "route_latency");
        send_byte(8'h01, 2);
        send_byte(8'h03, 2);
        send_byte(8'hAA, 2);
        send_byte(8'hBB, 2);
        send_byte(8'hCC, 2);
        drain_port(2, 6);
        check_valid('0, "route_others_empty");
`ifdef PKT_SWITCH_STATS_EN
        cfg_check(N + 2, 8'd1, "stats_fwd2");
`endif
    endtask

    task automatic test_drop();
        logic [7:0] pkt [5];
        pkt = '{8'h77, 8'h01, 8'h02, 8'h11, 8'h22};
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL drop_ready: in_ready got %b expected 1 at byte %0d", in_ready, k);
            end
            send_byte(pkt[k], -1);
        end
        check_valid('0, "drop_no_write");
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        send_byte(8'h99, 0);
        drain_port(0, 4);
        check_valid('0, "drop_after_empty");
`ifdef PKT_SWITCH_STATS_EN
        cfg_check(2*N, 8'd1, "stats_drop");
        cfg_check(N, 8'd1, "stats_fwd0");
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] pkt [20];
        pkt[0] = 8'h01;
        pkt[1] = 8'h02;
        pkt[2] = 8'd17;
        for (int j = 0; j < 17; j++) pkt[3+j] = 8'hA0 + 8'(j);
        for (int k = 0; k < 16; k++) send_byte(pkt[k], 1);
        in_data  = pkt[16];
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stall: in_ready got %b expected 0 (cycle %0d)", in_ready, c);
            end
            tick();
        end
        check_valid(4'b0010, "bp_valid");
        fork
            begin
                for (int k = 16; k < 20; k++) send_byte(pkt[k], 1);
            end
            drain_port(1, 20);
        join
        check_valid('0, "bp_empty");
    endtask

    task automatic test_dup_zero_len();
        cfg_write(0, 8'h10);
        cfg_write(3, 8'h10);
        send_byte(8'h10, 0);
        send_byte(8'h07, 0);
        send_byte(8'h00, 0);
        check_valid(4'b0001, "dup_port0_only");
        send_byte(8'h01, 1);
        send_byte(8'h08, 1);
        send_byte(8'h00, 1);
        check_valid(4'b0011, "zero_len_idle");
        drain_port(0, 3);
        drain_port(1, 3);
        check_valid('0, "dup_empty");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h05, 1);
        send_byte(8'hAA, 1);
        check_valid(4'b0010, "mid_pre_reset");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_valid('0, "mid_flush");
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_ready: in_ready got %b expected 1", in_ready);
        end
        exp_q[1].delete();
        out_read = '1;
        tick();
        out_read = '0;
        check_valid('0, "pop_empty_ignored");
        cfg_check(0, 8'h00, "mid_addr_reset");
        send_byte(8'h02, 2);
        send_byte(8'h03, 2);
        send_byte(8'h01, 2);
        send_byte(8'h44, 2);
        drain_port(2, 4);
        check_valid('0, "mid_fresh_empty");
    endtask

    initial begin
        test_reset();
        test_route();
        test_drop();
        test_backpressure();
        test_dup_zero_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
